// File: rtl/mem_dump_reader.sv
// mem_dump_reader
//   Streams a block of 32-bit words out of a synchronous data memory as a
//   little-endian byte stream over a valid/ready handshake.
//
//   Ports
//     clock_i       single clock, all state on the rising edge
//     reset_ni      asynchronous active-low reset
//     start_i       dump request, only looked at in IDLE
//     base_addr_i   first word address, latched on an accepted start
//     word_count_i  number of words to dump, latched on an accepted start
//     mem_rd_en_o   memory read strobe (one cycle per word)
//     mem_addr_o    memory word address
//     mem_rdata_i   memory read data, valid the cycle after mem_rd_en_o
//     tx_data_o     outgoing byte
//     tx_valid_o    tx_data_o holds a valid byte
//     tx_ready_i    sink accepts the byte this edge when tx_valid_o is high
//     tx_last_o     final byte of the dump
//     busy_o        a dump is in progress
//     done_o        one-cycle completion pulse
module mem_dump_reader #(
    parameter int ADDR_W = 8
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   word_count_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              tx_last_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W:0]   cnt_q,   cnt_d;    // words still to send, incl. current
    logic [1:0]        idx_q,   idx_d;    // byte lane within the current word
    logic [31:0]       word_q,  word_d;

    logic last_word;
    assign last_word = (cnt_q == CNT_ONE);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        word_d      = word_q;
        mem_rd_en_o = 1'b0;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        tx_last_o   = 1'b0;
        done_o      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (word_count_i != CNT_ZERO) begin
                        addr_d  = base_addr_i;
                        cnt_d   = word_count_i;
                        state_d = S_READ;
                    end else begin
                        // Empty dump: report completion without touching memory.
                        state_d = S_DONE;
                    end
                end
            end

            S_READ: begin
                mem_rd_en_o = 1'b1;
                state_d     = S_WAIT;
            end

            S_WAIT: begin
                // Memory answers one cycle after the strobe.
                word_d  = mem_rdata_i;
                idx_d   = 2'd0;
                state_d = S_SEND;
            end

            S_SEND: begin
                // Outputs depend only on registered state, so they hold
                // steady across any number of stalled cycles.
                tx_valid_o = 1'b1;
                tx_data_o  = word_q[{idx_q, 3'b000} +: 8];
                tx_last_o  = (idx_q == 2'd3) && last_word;
                if (tx_ready_i) begin
                    if (idx_q == 2'd3) begin
                        cnt_d   = cnt_q - CNT_ONE;
                        addr_d  = addr_q + ADDR_ONE;   // wraps naturally
                        state_d = last_word ? S_DONE : S_READ;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr_o = addr_q;
    // DONE reports completion with busy already dropped.
    assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
